zuc_eea3_crypt: RTL and testbench

- EEA3 confidentiality engine that consumes keystream from the ZUC keystream core; it sits on the consumer side of the core's init/start/KEY/IV/Z interface.
- Per message: builds the 128-bit IV from COUNT/BEARER/DIRECTION, loads CK/IV into the core, then XORs 32-bit keystream words onto a streamed data payload.
- The same operation performs encryption and decryption.
- Sits between the packet datapath (valid/ready streams) and the keystream core.

---
 rtl/zuc_pkg.sv | 31 +++
 rtl/zuc_ks_fifo.sv | 57 +++++
 rtl/zuc_eea3_crypt.sv | 154 +++++++++++++++
 tb/tb_zuc_eea3_crypt.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zuc_pkg.sv
// Shared types and helpers for the EEA3 confidentiality engine.
// Holds the FSM encoding, the IV byte layout and the last-word mask.
package zuc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_RUN,
      ST_DRAIN
   } state_t;

   localparam int         IV_HALF_W = 64;
   localparam logic [1:0] IV4_PAD   = 2'b00;
   localparam logic [23:0] IV5_7    = 24'h000000;

   // IV0..7 = COUNT bytes, {BEARER,DIR,00}, three zero bytes; IV8..15 repeat them.
   function automatic logic [127:0] build_iv(input logic [31:0] count,
                                             input logic [4:0]  bearer,
                                             input logic        dir);
      logic [IV_HALF_W-1:0] half;
      half = {count, bearer, dir, IV4_PAD, IV5_7};
      return {half, half};
   endfunction

   // Keeps the lb most significant bits; lb == 0 means the word is full.
   function automatic logic [31:0] last_mask(input logic [4:0] lb);
      return (lb == 5'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> lb);
   endfunction

endpackage

// File: rtl/zuc_ks_fifo.sv
// Keystream skid buffer between the keystream core and the XOR datapath.
// Flush empties it in one cycle; push while full is accepted only alongside a pop.
module zuc_ks_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign head_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/zuc_eea3_crypt.sv
// EEA3 engine: loads CK/IV into the keystream core, then XORs keystream onto the payload.
// One word per cycle, one cycle din->dout latency; output register stalls on dout_ready_i.
module zuc_eea3_crypt
   import zuc_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int LEN_W      = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [127:0]     cfg_ck_i,
   input  logic [31:0]      cfg_count_i,
   input  logic [4:0]       cfg_bearer_i,
   input  logic             cfg_dir_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   output logic             ks_init_o,
   output logic             ks_start_o,
   output logic [127:0]     ks_key_o,
   output logic [127:0]     ks_iv_o,
   input  logic             ks_valid_i,
   input  logic [31:0]      ks_word_i,
   output logic             ks_ready_o,
   input  logic             din_valid_i,
   output logic             din_ready_o,
   input  logic [31:0]      din_data_i,
   output logic             dout_valid_o,
   input  logic             dout_ready_i,
   output logic [31:0]      dout_data_o,
   output logic             dout_last_o,
   output logic             busy_o
);

   localparam int NW_W = LEN_W - 4;

   state_t           state_q;
   logic [127:0]     key_q;
   logic [127:0]     iv_q;
   logic [NW_W-1:0]  nw_q;
   logic [NW_W-1:0]  wcnt_q;
   logic [4:0]       lb_q;
   logic [31:0]      dout_data_q;
   logic             dout_last_q;
   logic             dout_valid_q;
   logic             ks_init_q;
   logic             ks_start_q;

   logic [LEN_W:0]   len_rnd;
   logic [NW_W-1:0]  nw_d;
   logic [31:0]      dout_data_d;
   logic [31:0]      ks_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_flush;
   logic             fifo_push;
   logic             out_free;
   logic             is_last;
   logic             fire;

   // A zero length is illegal; it is folded into a single full word.
   assign len_rnd = {1'b0, cfg_len_i} + (LEN_W+1)'(31);
   assign nw_d    = (len_rnd[LEN_W:5] == '0) ? NW_W'(1) : len_rnd[LEN_W:5];

   assign out_free    = !dout_valid_q || dout_ready_i;
   assign din_ready_o = (state_q == ST_RUN) && !fifo_empty && out_free && (wcnt_q != nw_q);
   assign fire        = din_valid_i && din_ready_o;
   assign is_last     = (wcnt_q + NW_W'(1)) == nw_q;
   assign dout_data_d = (din_data_i ^ ks_head) & (is_last ? last_mask(lb_q) : 32'hFFFF_FFFF);

   assign ks_ready_o = ((state_q == ST_RUN) && !fifo_full) || (state_q == ST_DRAIN);
   assign fifo_push  = ks_valid_i && ks_ready_o;
   assign fifo_flush = (state_q == ST_DRAIN);

   zuc_ks_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_ks_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (ks_word_i),
      .pop_i       (fire),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (ks_head)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         key_q        <= '0;
         iv_q         <= '0;
         nw_q         <= '0;
         wcnt_q       <= '0;
         lb_q         <= '0;
         dout_data_q  <= '0;
         dout_last_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         ks_init_q    <= 1'b0;
         ks_start_q   <= 1'b0;
      end else begin
         ks_init_q  <= 1'b0;
         ks_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cfg_valid_i) begin
                  key_q     <= cfg_ck_i;
                  iv_q      <= build_iv(cfg_count_i, cfg_bearer_i, cfg_dir_i);
                  nw_q      <= nw_d;
                  lb_q      <= cfg_len_i[4:0];
                  wcnt_q    <= '0;
                  ks_init_q <= 1'b1;
                  state_q   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               ks_start_q <= 1'b1;
               state_q    <= ST_START;
            end
            ST_START: state_q <= ST_RUN;
            ST_RUN: begin
               if (fire) begin
                  dout_data_q  <= dout_data_d;
                  dout_last_q  <= is_last;
                  dout_valid_q <= 1'b1;
                  wcnt_q       <= wcnt_q + NW_W'(1);
               end else if (dout_ready_i) begin
                  dout_valid_q <= 1'b0;
               end
               // The final word cannot fire again, so this handshake closes the message.
               if (dout_valid_q && dout_ready_i && dout_last_q) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               dout_last_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign ks_init_o    = ks_init_q;
   assign ks_start_o   = ks_start_q;
   assign ks_key_o     = key_q;
   assign ks_iv_o      = iv_q;
   assign dout_valid_o = dout_valid_q;
   assign dout_data_o  = dout_data_q;
   assign dout_last_o  = dout_last_q;

endmodule

// File: tb/tb_zuc_eea3_crypt.sv
// Randomised scoreboard bench for zuc_eea3_crypt with a stub keystream core.
module tb_zuc_eea3_crypt;

   localparam int FIFO_DEPTH = 2;
   localparam int LEN_W      = 32;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cfg_valid, cfg_ready, cfg_dir;
   logic [127:0]     cfg_ck;
   logic [31:0]      cfg_count;
   logic [4:0]       cfg_bearer;
   logic [LEN_W-1:0] cfg_len;
   logic             ks_init, ks_start, ks_valid, ks_ready;
   logic [127:0]     ks_key, ks_iv;
   logic [31:0]      ks_word;
   logic             din_valid, din_ready, dout_valid, dout_ready, dout_last, busy;
   logic [31:0]      din_data, dout_data;

   zuc_eea3_crypt #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ck_i(cfg_ck),
      .cfg_count_i(cfg_count), .cfg_bearer_i(cfg_bearer), .cfg_dir_i(cfg_dir), .cfg_len_i(cfg_len),
      .ks_init_o(ks_init), .ks_start_o(ks_start), .ks_key_o(ks_key), .ks_iv_o(ks_iv),
      .ks_valid_i(ks_valid), .ks_word_i(ks_word), .ks_ready_o(ks_ready),
      .din_valid_i(din_valid), .din_ready_o(din_ready), .din_data_i(din_data),
      .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data),
      .dout_last_o(dout_last), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, cyc = 0;
   int ks_pct = 100, din_pct = 100, rdy_pct = 100;
   int out_cnt = 0, last_hs_cyc = -100, acc_cyc = 0;

   logic [31:0]  din_q[$], ks_q[$], ks_stage_q[$], msg_pt[$], msg_ks[$];
   int           ks_cnt_q[$];
   logic [32:0]  exp_q[$];
   logic [127:0] key_exp_q[$], iv_exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: expected output = payload XOR keystream, trimmed to the message bit length.
   task automatic prep_msg(input logic [127:0] ck, input logic [31:0] count, input logic [4:0] bearer,
                           input logic dir, input int len);
      int nw, nb;
      logic [31:0] x;
      logic [7:0] ivb [16];
      logic [127:0] iv;
      nw = (len + 31) / 32;
      for (int i = 0; i < nw; i++) begin
         x = msg_pt[i] ^ msg_ks[i];
         if (i == nw - 1) begin
            nb = len - 32 * (nw - 1);
            for (int b = nb; b < 32; b++) x[31-b] = 1'b0;
         end
         din_q.push_back(msg_pt[i]);
         ks_stage_q.push_back(msg_ks[i]);
         exp_q.push_back({(i == nw - 1), x});
      end
      ks_cnt_q.push_back(nw);
      ivb[0] = count[31:24]; ivb[1] = count[23:16]; ivb[2] = count[15:8]; ivb[3] = count[7:0];
      ivb[4] = 8'(int'(bearer) * 8 + int'(dir) * 4);
      for (int i = 5; i < 8; i++) ivb[i] = 8'h00;
      for (int i = 8; i < 16; i++) ivb[i] = ivb[i-8];
      iv = '0;
      for (int i = 0; i < 16; i++) iv = {iv[119:0], ivb[i]};
      key_exp_q.push_back(ck);
      iv_exp_q.push_back(iv);
      cfg_ck = ck; cfg_count = count; cfg_bearer = bearer; cfg_dir = dir; cfg_len = LEN_W'(len);
   endtask

   task automatic fill_random(input int len);
      msg_pt.delete(); msg_ks.delete();
      for (int i = 0; i < (len + 31) / 32; i++) begin
         msg_pt.push_back($urandom); msg_ks.push_back($urandom);
      end
   endtask

   task automatic issue_cfg();
      bit ok = 0;
      cfg_valid = 1'b1;
      for (int t = 0; t < 6000 && !ok; t++) begin
         @(negedge clk);
         if (cfg_ready) begin ok = 1; acc_cyc = cyc + 1; end
      end
      check("cfg_accept_timeout", ok, 1'b1);
      @(posedge clk); #2;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int t = 0; t < 8000 && !ok; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && cfg_ready) ok = 1;
      end
      check("msg_done_timeout", ok, 1'b1);
      @(posedge clk); #2;
   endtask

   // Stub keystream core: loads a message's words on ks_init, offers them with random gaps.
   initial begin
      logic tk, prev_init, prev_start;
      logic [127:0] ek, ei;
      int n;
      ks_valid = 1'b0; ks_word = '0; prev_init = 1'b0; prev_start = 1'b0; ek = '0; ei = '0;
      forever begin
         @(negedge clk);
         tk = ks_valid && ks_ready;
         if (ks_init) begin
            check("ks_init_width", {prev_init, prev_start}, 2'b00);
            if (key_exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL ks_init_unexpected: got pulse expected none");
            end else begin
               ek = key_exp_q.pop_front(); ei = iv_exp_q.pop_front();
               check("ks_key_at_init", ks_key, ek);
               check("ks_iv_at_init", ks_iv, ei);
               ks_q.delete();
               n = ks_cnt_q.pop_front();
               repeat (n) ks_q.push_back(ks_stage_q.pop_front());
               repeat (3) ks_q.push_back($urandom);
            end
         end
         if (ks_start) begin
            check("ks_start_after_init", prev_init, 1'b1);
            check("ks_key_at_start", ks_key, ek);
            check("ks_iv_at_start", ks_iv, ei);
         end
         prev_init = ks_init; prev_start = ks_start;
         @(posedge clk); #1;
         if (tk && ks_q.size() > 0) ks_q.delete(0);
         ks_valid = (ks_q.size() > 0) && ($urandom_range(99) < ks_pct);
         ks_word  = (ks_q.size() > 0) ? ks_q[0] : 32'h0;
      end
   end

   initial begin
      logic tk;
      din_valid = 1'b0; din_data = '0;
      forever begin
         @(negedge clk);
         tk = din_valid && din_ready;
         @(posedge clk); #1;
         if (tk && din_q.size() > 0) din_q.delete(0);
         din_valid = (din_q.size() > 0) && ($urandom_range(99) < din_pct);
         din_data  = (din_q.size() > 0) ? din_q[0] : 32'h0;
      end
   end

   initial begin
      dout_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         dout_ready = ($urandom_range(99) < rdy_pct);
      end
   end

   // Monitor: scoreboard pops, output hold under backpressure, ks_ready vs FIFO occupancy.
   initial begin
      logic [32:0] e, hold_d;
      logic hold_v, in_run;
      int occ;
      hold_v = 1'b0; hold_d = '0; in_run = 1'b0; occ = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            hold_v = 1'b0; in_run = 1'b0; occ = 0;
         end else begin
            if (hold_v) check("dout_hold", {dout_valid, dout_last, dout_data}, {1'b1, hold_d});
            hold_v = dout_valid && !dout_ready;
            hold_d = {dout_last, dout_data};
            if (in_run) begin
               if (occ >= FIFO_DEPTH) check("ks_ready_when_full", ks_ready, 1'b0);
               occ = occ + int'(ks_valid && ks_ready) - int'(din_valid && din_ready);
            end
            if (ks_start) begin in_run = 1'b1; occ = 0; end
            if (dout_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL dout_unexpected: got %h last %b expected no word", dout_data, dout_last);
               end else begin
                  e = exp_q.pop_front();
                  check("dout_data", dout_data, e[31:0]);
                  check("dout_last", dout_last, e[32]);
               end
               out_cnt++;
               if (dout_last) begin
                  last_hs_cyc = cyc + 1; in_run = 1'b0; occ = 0;
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit ok;
      cfg_valid = 1'b0; cfg_ck = '0; cfg_count = '0; cfg_bearer = '0; cfg_dir = 1'b0; cfg_len = '0;
      repeat (3) @(posedge clk); #2;
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ks_init", ks_init, 1'b0);
      check("rst_ks_start", ks_start, 1'b0);
      check("rst_ks_ready", ks_ready, 1'b0);
      check("rst_din_ready", din_ready, 1'b0);
      check("rst_dout_valid", dout_valid, 1'b0);
      check("rst_dout_last", dout_last, 1'b0);
      check("rst_dout_data", dout_data, 32'h0);
      check("rst_ks_key", ks_key, 128'h0);
      check("rst_ks_iv", ks_iv, 128'h0);
      rstn = 1'b1;
      @(posedge clk); #2;

      // EEA3 test set 1: first keystream word chosen so word0 = 6cf65340 -> a6c85fc6.
      fill_random(193);
      msg_pt[0] = 32'h6cf65340; msg_ks[0] = 32'hca3e0c86;
      prep_msg(128'h173d14ba5003731d7a60049470f00a29, 32'h66035492, 5'h0f, 1'b0, 193);
      issue_cfg(); wait_done();

      msg_pt = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; msg_ks = {32'h1, 32'h2};
      prep_msg(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 32'h1, 5'h3, 1'b1, 64);
      issue_cfg(); wait_done();

      msg_pt = {32'h1234_5678, 32'hAABB_CCDD}; msg_ks = {32'h0, 32'h0};
      prep_msg(128'h5, 32'hFFFF_FFFF, 5'h1f, 1'b1, 40);
      issue_cfg(); wait_done();

      rdy_pct = 50; ks_pct = 60; din_pct = 85;
      fill_random(1024);
      prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), 1024);
      issue_cfg(); wait_done();

      // Reset during RUN, then a fresh message must complete cleanly.
      rdy_pct = 100; ks_pct = 100; din_pct = 100;
      base = out_cnt;
      fill_random(512);
      prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), 512);
      issue_cfg();
      ok = 0;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk);
         if (out_cnt >= base + 3) ok = 1;
      end
      check("run_words_timeout", ok, 1'b1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      check("midrst_cfg_ready", cfg_ready, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_dout_valid", dout_valid, 1'b0);
      check("midrst_ks_pulses", {ks_init, ks_start}, 2'b00);
      din_q.delete(); exp_q.delete();
      @(posedge clk); #2;
      rstn = 1'b1;
      @(posedge clk); #2;
      fill_random(100);
      prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), 100);
      issue_cfg(); wait_done();

      // cfg_valid held while busy: accepted two cycles after the last-word handshake.
      rdy_pct = 70;
      fill_random(96);
      prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), 96);
      issue_cfg();
      fill_random(64);
      prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), 64);
      issue_cfg();
      check("cfg_hold_gap", acc_cyc - last_hs_cyc, 2);
      wait_done();

      for (int m = 0; m < 6; m++) begin
         int len;
         len = $urandom_range(300, 1);
         rdy_pct = $urandom_range(100, 40); ks_pct = $urandom_range(100, 40); din_pct = $urandom_range(100, 40);
         fill_random(len);
         prep_msg({$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom), len);
         issue_cfg(); wait_done();
      end

      repeat (5) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
